// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register carrying a payload and a control bundle between CPU stages.
// Define PIPE_SKID_EN for a 2-entry skid variant with no out_ready->in_ready combinational path.
module pipe_stage_reg #(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned CTRL_W = 10,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   logic              accept;
   logic              emit;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign emit   = valid_q & out_ready;
   assign accept = in_valid & in_ready;

`ifdef PIPE_SKID_EN
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

   // Ready depends only on local state, breaking the backward ready chain.
   assign in_ready = reset_n & ~stall & ~flush & ~skid_valid_q;

   always_comb begin
      valid_d      = valid_q;
      data_d       = data_q;
      ctrl_d       = ctrl_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_ctrl_d  = skid_ctrl_q;
      if (flush) begin
         valid_d      = 1'b0;
         ctrl_d       = '0;
         skid_valid_d = 1'b0;
         skid_ctrl_d  = '0;
      end else if (emit) begin
         if (skid_valid_q) begin
            valid_d      = 1'b1;
            data_d       = skid_data_q;
            ctrl_d       = skid_ctrl_q;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
         end else if (accept) begin
            valid_d = 1'b1;
            data_d  = in_data;
            ctrl_d  = in_ctrl;
         end else begin
            valid_d = 1'b0;
            ctrl_d  = '0;
         end
      end else if (accept) begin
         if (valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_ctrl_d  = in_ctrl;
         end else begin
            valid_d = 1'b1;
            data_d  = in_data;
            ctrl_d  = in_ctrl;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_ctrl_q  <= '0;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_ctrl_q  <= skid_ctrl_d;
      end
   end
`else
   assign in_ready = reset_n & ~stall & ~flush & (~valid_q | out_ready);

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      if (flush) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else if (accept) begin
         valid_d = 1'b1;
         data_d  = in_data;
         ctrl_d  = in_ctrl;
      end else if (emit) begin
         // Payload is left as-is; only control must read as zero when empty.
         valid_d = 1'b0;
         ctrl_d  = '0;
      end
   end
`endif

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (out_ready && !valid_q && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_data   = data_q;
   assign out_ctrl   = ctrl_q;
   assign bubble_cnt = cnt_q;

endmodule
